// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider issue stage: default widths, the FSM
// state encoding, the result record carried through the result FIFO and the
// quotient value reported for a divide-by-zero.
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_N    = 19;   // default operand/result width
    localparam int DIV_TAGW = 4;    // default user tag width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [DIV_N-1:0]    quotient;
        logic [DIV_N-1:0]    remainder;
        logic [DIV_TAGW-1:0] tag;
        logic                dbz;
    } div_result_t;

    // Quotient reported when the divisor is zero (all ones).
    localparam logic [DIV_N-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_result_fifo.sv
// ---------------------------------------------------------------------------
// div_result_fifo
// First-word-fall-through FIFO for completed division results. Storage is a
// register array; the head entry is presented combinationally from the read
// pointer so a result is visible the cycle after it is pushed.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (empties the FIFO)
//   push       in   write push_data (ignored when full)
//   push_data  in   entry to write
//   pop        in   discard head entry (ignored when empty)
//   head_data  out  head entry, all zeros while empty
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   count      out  number of entries held
// ---------------------------------------------------------------------------
module div_result_fifo
    import div_pkg::*;
#(
    parameter int  DEPTH = 4,               // power of two, >= 2
    parameter type T     = div_result_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    T              r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers are exactly AW bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;   // idle, or push+pop together
            endcase
        end
    end

    // Storage carries no reset; stale contents are masked by the empty flag.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW + 1)'(DEPTH));
    assign count     = r_count;
    assign head_data = empty ? T'('0) : r_mem[r_rd_ptr];

endmodule

// File: rtl/div_issue_unit.sv
// ---------------------------------------------------------------------------
// div_issue_unit
// Issue stage in front of a combinational unsigned divider. One operation is
// in flight at a time: the operands are registered onto div_dividend /
// div_divisor and held for SETTLE cycles (multicycle path) before the
// divider's quotient/remainder are sampled into a result FIFO. A zero divisor
// bypasses the divider and produces {all ones, dividend} with dbz set.
//
// Ports:
//   clk, rst                      clock / asynchronous active-high reset
//   in_valid, in_ready            request handshake
//   in_dividend, in_divisor       operands
//   in_tag                        user tag returned with the result
//   div_dividend, div_divisor     registered operands driving the divider
//   div_quotient, div_remainder   divider outputs, sampled after settling
//   out_valid, out_ready          result handshake (FWFT)
//   out_quotient, out_remainder   result data
//   out_tag, out_dbz              result tag and divide-by-zero flag
//   busy                          operation in flight or results pending
// ---------------------------------------------------------------------------
module div_issue_unit
    import div_pkg::*;
#(
    parameter int N      = DIV_N,
    parameter int SETTLE = 4,        // legal range 1..15
    parameter int DEPTH  = 4,        // power of two, >= 2
    parameter int TAGW   = DIV_TAGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_dividend,
    input  logic [N-1:0]    in_divisor,
    input  logic [TAGW-1:0] in_tag,
    output logic [N-1:0]    div_dividend,
    output logic [N-1:0]    div_divisor,
    input  logic [N-1:0]    div_quotient,
    input  logic [N-1:0]    div_remainder,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_quotient,
    output logic [N-1:0]    out_remainder,
    output logic [TAGW-1:0] out_tag,
    output logic            out_dbz,
    output logic            busy
);

    // Result record sized by this instance's parameters.
    typedef struct packed {
        logic [N-1:0]    quotient;
        logic [N-1:0]    remainder;
        logic [TAGW-1:0] tag;
        logic            dbz;
    } res_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_next;
    logic [N-1:0]     r_dividend;
    logic [N-1:0]     r_divisor;
    logic [TAGW-1:0]  r_tag;
    logic             r_dbz;

    logic                   w_accept;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;
    res_t                   w_push_data;
    res_t                   w_head;

    // Accepting only with FIFO space guarantees CAPTURE always has room.
    assign in_ready = !rst && (r_state == IDLE) && !w_full;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // State, settle counter and operand/holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Operands only move on an accepted request, so the divider inputs are
    // glitch-free for the whole WAIT/CAPTURE window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_tag      <= '0;
            r_dbz      <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= in_dividend;
            r_divisor  <= in_divisor;
            r_tag      <= in_tag;
            r_dbz      <= (in_divisor == '0);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_divisor == '0) begin
                        w_state_next = CAPTURE;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // Counts SETTLE-1 down to 0: exactly SETTLE cycles in WAIT.
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                w_push       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Divide-by-zero results never look at the divider outputs.
    always_comb begin
        w_push_data.tag = r_tag;
        w_push_data.dbz = r_dbz;
        if (r_dbz) begin
            w_push_data.quotient  = '1;
            w_push_data.remainder = r_dividend;
        end else begin
            w_push_data.quotient  = div_quotient;
            w_push_data.remainder = div_remainder;
        end
    end

    div_result_fifo #(
        .DEPTH (DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (out_ready),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_fifo_count)
    );

    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign out_valid     = !w_empty;
    assign out_quotient  = w_head.quotient;
    assign out_remainder = w_head.remainder;
    assign out_tag       = w_head.tag;
    assign out_dbz       = w_head.dbz;
    assign busy          = (r_state != IDLE) || !w_empty;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full));

endmodule

// File: doc/div_issue_unit.md
Name: div_issue_unit

Overview:
- Sequencing stage directly upstream of the team's combinational N-bit unsigned divider. Accepts dividend/divisor pairs over a valid/ready stream.
- Holds each operand pair stable on registered outputs for a programmable settle time (multicycle path), then samples quotient/remainder.
- Handles divide-by-zero locally, without using the divider.
- Buffers tagged results in a small FIFO for a downstream valid/ready consumer.

Parameters:
N, 19, operand/result width
SETTLE, 4, cycles the divider operands are held before sampling (legal range 1..15)
DEPTH, 4, result FIFO depth (power of two, ≥2)
TAGW, 4, width of the user tag carried with each operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_dividend  in  N  dividend
in_divisor  in  N  divisor
in_tag  in  TAGW  user tag
div_dividend  out  N  registered dividend to divider
div_divisor  out  N  registered divisor to divider
div_quotient  in  N  divider quotient, valid after settle
div_remainder  in  N  divider remainder, valid after settle
out_valid  out  1  result available
out_ready  in  1  consumer pops when out_valid && out_ready
out_quotient  out  N  quotient
out_remainder  out  N  remainder
out_tag  out  TAGW  tag of this result
out_dbz  out  1  divide-by-zero flag
busy  out  1  high while state != IDLE or FIFO non-empty

Behaviour:
- Reset (async assert, synchronous deassert by usage):
  - state=IDLE; div_dividend=div_divisor=0; tag and dbz holding registers = 0.
  - FIFO empty; out_valid=0; out_* data=0; busy=0.
  - in_ready forced 0 while rst high.
- FSM states:
  - IDLE: in_ready = !fifo_full. On handshake, latch in_dividend/in_divisor/in_tag into the holding and div_* registers.
    - If in_divisor==0: go to CAPTURE with dbz=1.
    - Otherwise: go to WAIT with cnt=SETTLE-1, dbz=0.
  - WAIT: in_ready=0. If cnt!=0, cnt--. If cnt==0, go to CAPTURE. WAIT lasts exactly SETTLE cycles.
  - CAPTURE: in_ready=0. Push {quotient, remainder, tag, dbz} into the FIFO, then go to IDLE.
    - Normal: quotient=div_quotient, remainder=div_remainder.
    - dbz=1: quotient=all ones (2^N-1), remainder=latched dividend; div_quotient/div_remainder ignored.
- Timing, with handshake in cycle k:
  - Normal op: CAPTURE in cycle k+SETTLE+1; out_valid high from cycle k+SETTLE+2 if the FIFO was empty.
  - DBZ op: CAPTURE in cycle k+1; out_valid from cycle k+2.
  - Peak throughput: one normal op per SETTLE+2 cycles.
- Exactly one operation in flight. in_ready requires FIFO not full at accept, so CAPTURE never pushes into a full FIFO. No overflow path is needed; an assertion checks it.
- div_* outputs only change on an IDLE handshake and stay constant during WAIT/CAPTURE. Glitch-free operands are required for the multicycle constraint.
- FIFO is first-word-fall-through with registered storage:
  - out_* reflect the head entry. They stay stable while out_valid && !out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - out_valid = !empty.
- Reset mid-operation: the in-flight op is discarded, no partial result appears, and all FIFO entries are dropped.
- in_valid deasserted in IDLE: FSM stays in IDLE and holding registers keep their last values.

Decomposition:
- Package div_pkg holds:
  - localparam defaults for N and TAGW
  - state enum {IDLE, WAIT, CAPTURE}
  - result struct {quotient, remainder, tag, dbz}
  - DBZ_QUOTIENT constant (all ones)
- Sub-module div_result_fifo: parameterized FWFT FIFO over the result struct (DEPTH), with push, pop, full, empty and count.
- The top module holds the FSM, the settle counter and the operand registers.

Test Plan:
1. Request 100/7, tag 3, SETTLE=4, out_ready=1, bench divider model attached -> exactly 6 cycles after the handshake: out_valid=1 with q=14, r=2, tag=3, dbz=0. in_ready low for 5 cycles.
2. Request 12345/0, tag 9 -> two cycles after the handshake: q=0x7FFFF, r=12345, tag=9, dbz=1. Divider outputs are ignored, so the bench drives X on them.
3. out_ready=0, issue 5 back-to-back requests (tags 0..4) -> four results queue, and in_ready stays 0 after the 4th capture. Raise out_ready -> results pop in order 0..3, then request 4 is accepted and completes.
4. Pop the head in the same cycle CAPTURE pushes, with FIFO holding 2 entries -> count stays 2, order preserved, no loss.
5. Assert rst during WAIT of 50000/3, with one result already queued -> out_valid=0, busy=0, FIFO empty, div_* = 0. The next request 9/4 yields q=2, r=1.
6. Boundary operands 0x7FFFF/1 and 0/5 -> results (0x7FFFF, 0) and (0, 0). div_* stay constant across the whole WAIT window (checked every cycle).
